// File: rtl/fp_subnorm_round16.sv
// FP16 result packer: denormalizes by a multi-cycle right shift, rounds, and
// handles NaN/Inf/zero/overflow. Define FP_SUBNORM_ROUND16_RNE_EN for round-to-nearest-even, else truncate.
module fp_subnorm_round16 #(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        i_sign,
  input  logic [7:0]  i_exp,
  input  logic [10:0] i_sig,
  input  logic        i_nan,
  input  logic        i_inf,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [15:0] o,
  output logic        o_uf,
  output logic        o_of
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic       nan;
    logic       inf;
    logic       zero;
  } op_t;

  state_t      state, state_n;
  op_t         op_q;
  logic [10:0] sig_q, s;
  logic        grd_q, stk_q, g, st;
  logic [3:0]  cnt_q, rem, cnt_init;
  logic [8:0]  need;
  logic        accept, exp_nonpos, sig_nz;
  logic        inc;
  logic [10:0] r;
  logic [15:0] res;
  logic        res_uf, res_of;

  assign accept     = i_valid & i_ready & ce;
  assign exp_nonpos = $signed(i_exp) <= 8'sd0;
  assign sig_nz     = |i_sig;
  // Only meaningful when i_exp <= 0, where 1 - i_exp lies in 1..129
  assign need       = 9'd1 - {i_exp[7], i_exp};
  assign cnt_init   = (need > 9'd12) ? 4'd12 : need[3:0];

  // One pass shifts up to SHIFT_PER_CYCLE bits; old guard folds into sticky
  always_comb begin
    s   = sig_q;
    g   = grd_q;
    st  = stk_q;
    rem = cnt_q;
    for (int j = 0; j < SHIFT_PER_CYCLE; j++) begin
      if (rem != 4'd0) begin
        st  = st | g;
        g   = s[0];
        s   = {1'b0, s[10:1]};
        rem = rem - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ce) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (exp_nonpos && sig_nz) ? SHIFT : ROUND;
      SHIFT:   if (rem == 4'd0) state_n = ROUND;
      ROUND:   state_n = OUT;
      OUT:     if (o_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    i_ready = (state == IDLE);
    o_valid = (state == OUT);
  end

  // A carry out of the 10-bit fraction lands in bit 10, i.e. exponent field 1
  always_comb begin
`ifdef FP_SUBNORM_ROUND16_RNE_EN
    inc = grd_q & (stk_q | sig_q[0]);
`else
    inc = 1'b0;
`endif
    r      = sig_q + {10'd0, inc};
    res    = 16'h0000;
    res_uf = 1'b0;
    res_of = 1'b0;
    if (op_q.nan)
      res = {op_q.sign, 5'h1F, 1'b1, 9'h000};
    else if (op_q.inf)
      res = {op_q.sign, 5'h1F, 10'h000};
    else if (op_q.zero)
      res = {op_q.sign, 15'h0000};
    else if ($signed(op_q.exp) >= 8'sd31) begin
      res    = {op_q.sign, 5'h1F, 10'h000};
      res_of = 1'b1;
    end else if ($signed(op_q.exp) >= 8'sd1)
      res = {op_q.sign, op_q.exp[4:0], sig_q[9:0]};
    else begin
      res    = {op_q.sign, 4'h0, r};
      res_uf = ~r[10] & (grd_q | stk_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      sig_q <= '0;
      grd_q <= 1'b0;
      stk_q <= 1'b0;
      cnt_q <= '0;
      o     <= 16'h0000;
      o_uf  <= 1'b0;
      o_of  <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= '{sign: i_sign, exp: i_exp, nan: i_nan, inf: i_inf, zero: ~sig_nz};
          sig_q <= i_sig;
          grd_q <= 1'b0;
          stk_q <= 1'b0;
          cnt_q <= cnt_init;
        end
        SHIFT: begin
          sig_q <= s;
          grd_q <= g;
          stk_q <= st;
          cnt_q <= rem;
        end
        ROUND: begin
          o    <= res;
          o_uf <= res_uf;
          o_of <= res_of;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subnorm_round16.sv
// Random + directed bench for fp_subnorm_round16 against an arithmetic FP16 model.
module tb_fp_subnorm_round16;
  localparam int SPC = 1;

  logic        clk = 1'b0;
  logic        rst_n, ce, i_valid, i_ready, i_sign, i_nan, i_inf;
  logic [7:0]  i_exp;
  logic [10:0] i_sig;
  logic        o_valid, o_ready, o_uf, o_of;
  logic [15:0] o;

  int n_chk = 0, n_fail = 0;
  logic [15:0] last_o;
  logic        last_uf;

  fp_subnorm_round16 #(.SHIFT_PER_CYCLE(SPC)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .i_valid(i_valid), .i_ready(i_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_sig(i_sig), .i_nan(i_nan), .i_inf(i_inf),
    .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_uf(o_uf), .o_of(o_of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Value-level FP16 model: scale sig by 2^-(1-e) and round the remainder
  task automatic model(input logic sg, input int e, input int sig, input logic nan, input logic inf,
                       output logic [15:0] xo, output logic xuf, output logic xof, output int lat);
    int cnt, q, rm, half;
    xuf = 0; xof = 0; lat = 2;
    if (e <= 0 && sig != 0) begin
      cnt = (1 - e > 12) ? 12 : 1 - e;
      lat = 2 + (cnt + SPC - 1) / SPC;
    end
    if (nan)            xo = {sg, 15'h7E00};
    else if (inf)       xo = {sg, 15'h7C00};
    else if (sig == 0)  xo = {sg, 15'h0000};
    else if (e >= 31) begin xo = {sg, 15'h7C00}; xof = 1; end
    else if (e >= 1)    xo = {sg, 15'((e << 10) | (sig & 32'h3FF))};
    else begin
      q    = sig >> cnt;
      rm   = sig & ((1 << cnt) - 1);
      half = 1 << (cnt - 1);
`ifdef FP_SUBNORM_ROUND16_RNE_EN
      if (rm > half || (rm == half && (q % 2) == 1)) q = q + 1;
`endif
      xo  = {sg, 15'(q)};
      xuf = (q < 1024) && (rm != 0);
    end
  endtask

  task automatic do_op(input logic sg, input int e, input int sig, input logic nan, input logic inf,
                       input int hold, input int ce_gap);
    logic [15:0] xo; logic xuf, xof; int lat, edges;
    model(sg, e, sig, nan, inf, xo, xuf, xof, lat);
    lat += ce_gap;
    @(negedge clk);
    i_sign = sg; i_exp = 8'(e); i_sig = 11'(sig); i_nan = nan; i_inf = inf;
    i_valid = 1'b1; o_ready = (hold == 0); ce = 1'b1;
    check("i_ready_idle", i_ready, 1'b1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    i_valid = 1'b0;
    if (ce_gap > 0) ce = 1'b0;
    while (!o_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges - 1 >= ce_gap) ce = 1'b1;
    end
    check("latency", edges, lat);
    check("o", o, xo);
    check("o_uf", o_uf, xuf);
    check("o_of", o_of, xof);
    last_o = o; last_uf = o_uf;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_o", o, xo);
      check("hold_valid", o_valid, 1'b1);
      check("hold_i_ready", i_ready, 1'b0);
    end
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("o_valid_drop", o_valid, 1'b0);
  endtask

  initial begin
    int e, sig;
    rst_n = 1'b0; ce = 1'b1; i_valid = 1'b0; i_sign = 0; i_exp = 0; i_sig = 0;
    i_nan = 0; i_inf = 0; o_ready = 1'b1;
    #12;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o", o, 16'h0000);
    check("rst_flags", {o_uf, o_of}, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    check("rst_i_ready", i_ready, 1'b1);

    do_op(0, 15, 'h400, 0, 0, 0, 0);
    check("one", last_o, 16'h3C00);
    do_op(0, 0, 'h600, 0, 0, 0, 0);
    check("sub_0300", last_o, 16'h0300);
    do_op(0, -9, 'h7FF, 0, 0, 0, 0);
`ifdef FP_SUBNORM_ROUND16_RNE_EN
    check("exp_m9", last_o, 16'h0002);
`else
    check("exp_m9", last_o, 16'h0001);
`endif
    check("exp_m9_uf", last_uf, 1'b1);
    do_op(0, 0, 'h7FF, 0, 0, 0, 0);
`ifdef FP_SUBNORM_ROUND16_RNE_EN
    check("carry_norm", last_o, 16'h0400);
`endif
    do_op(0, 40, 'h5A5, 0, 0, 0, 0);
    check("ovf", last_o, 16'h7C00);
    do_op(1, 3, 'h123, 1, 1, 3, 0);
    check("nan", last_o, 16'hFE00);
    do_op(1, -2, 'h4C3, 0, 0, 0, 2);
    do_op(0, -100, 'h000, 0, 0, 0, 0);
    do_op(1, -3, 'h700, 0, 1, 0, 0);

    // Reset mid-SHIFT must abort the operand and clear the outputs
    @(negedge clk);
    i_sign = 0; i_exp = 8'(-100); i_sig = 11'h555; i_valid = 1'b1; i_nan = 0; i_inf = 0;
    @(posedge clk);
    @(negedge clk); i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_o", o, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    check("midrst_i_ready", i_ready, 1'b1);
    do_op(0, 20, 'h6AB, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      e   = int'($urandom_range(0, 70)) - 30;
      sig = int'($urandom_range(0, 2047));
      if ($urandom_range(0, 15) == 0) sig = 0;
      do_op(1'($urandom_range(0, 1)), e, sig, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
